// File: rtl/biquad_df1.sv
// -----------------------------------------------------------------------------
// biquad_df1 -- second-order IIR section, Direct Form I.
//
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
//
// One shared signed multiplier is time-multiplexed by a small FSM. A sample
// is captured in IDLE, the five products are accumulated over five MAC
// cycles, and the result is scaled, saturated and written out in OUT.
// A sample therefore occupies the block for 7 clocks (capture edge to the
// next accepting edge).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in         signed input sample x[n] (n bits)
//   in_valid   one-cycle strobe, sample present on in
//   b0,b1,b2   signed feed-forward coefficients, Q(c-f).f
//   a1,a2      signed feedback coefficients (subtracted), Q(c-f).f
//   out        signed filtered sample y[n], registered, held between updates
//   out_valid  one-cycle strobe, out updated
//   busy       high while a sample is in MAC or OUT
//   sat        one-cycle pulse with out_valid when y was clipped
//   drop       one-cycle pulse after an in_valid that arrived while busy
// -----------------------------------------------------------------------------
module biquad_df1 #(
    parameter int n = 12,
    parameter int c = 12,
    parameter int f = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [n-1:0] in,
    input  logic                in_valid,
    input  logic signed [c-1:0] b0,
    input  logic signed [c-1:0] b1,
    input  logic signed [c-1:0] b2,
    input  logic signed [c-1:0] a1,
    input  logic signed [c-1:0] a2,
    output logic signed [n-1:0] out,
    output logic                out_valid,
    output logic                busy,
    output logic                sat,
    output logic                drop
);

    localparam int pw = n + c;      // full product width
    localparam int aw = n + c + 3;  // accumulator width, headroom for 5 terms

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_mac  = 2'd1;
    localparam logic [1:0] st_out  = 2'd2;

    logic [1:0] state;
    logic [2:0] k;

    // Sample history and the sample currently being processed.
    logic signed [n-1:0] x0, x1, x2, y1, y2;

    // Coefficients latched at capture so mid-computation changes are ignored.
    logic signed [c-1:0] cb0, cb1, cb2, ca1, ca2;

    logic signed [aw-1:0] acc;

    // Shared multiplier operands and result.
    logic signed [n-1:0]  mul_s;
    logic signed [c-1:0]  mul_c;
    logic                 mul_sub;
    logic signed [pw-1:0] prod;
    logic signed [aw-1:0] acc_next;

    // Output scaling and saturation.
    logic signed [aw-1:0] y_full;
    logic                 y_ovf;
    logic signed [n-1:0]  y_sat;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        mul_s   = '0;
        mul_c   = '0;
        mul_sub = 1'b0;
        case (k)
            3'd0: begin mul_s = x0; mul_c = cb0; end
            3'd1: begin mul_s = x1; mul_c = cb1; end
            3'd2: begin mul_s = x2; mul_c = cb2; end
            3'd3: begin mul_s = y1; mul_c = ca1; mul_sub = 1'b1; end
            3'd4: begin mul_s = y2; mul_c = ca2; mul_sub = 1'b1; end
            default: ;
        endcase
    end

    // Operands are sign-extended to the product width so the multiply is
    // done at full precision without relying on context-width rules.
    assign prod = {{c{mul_s[n-1]}}, mul_s} * {{n{mul_c[c-1]}}, mul_c};

    always_comb begin
        acc_next = acc;
        if (mul_sub)
            acc_next = acc - {{(aw-pw){prod[pw-1]}}, prod};
        else
            acc_next = acc + {{(aw-pw){prod[pw-1]}}, prod};
    end

    // Arithmetic right shift floors toward minus infinity. The result fits
    // in n bits only if all bits from the sign position upward agree.
    assign y_full = acc >>> f;
    assign y_ovf  = !((&y_full[aw-1:n-1]) || !(|y_full[aw-1:n-1]));

    always_comb begin
        y_sat = y_full[n-1:0];
        if (y_ovf)
            y_sat = y_full[aw-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    end

    assign busy = (state != st_idle);

    // NOTE: state is updated with non-blocking assignments so every register
    // here samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= st_idle;
            k         <= '0;
            acc       <= '0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            cb0       <= '0;
            cb1       <= '0;
            cb2       <= '0;
            ca1       <= '0;
            ca2       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
            // Any strobe outside IDLE, including the OUT->IDLE edge, is lost.
            drop      <= in_valid && (state != st_idle);

            case (state)
                st_idle: begin
                    if (in_valid) begin
                        x0    <= in;
                        cb0   <= b0;
                        cb1   <= b1;
                        cb2   <= b2;
                        ca1   <= a1;
                        ca2   <= a2;
                        acc   <= '0;
                        k     <= '0;
                        state <= st_mac;
                    end
                end
                st_mac: begin
                    acc <= acc_next;
                    if (k == 3'd4)
                        state <= st_out;
                    else
                        k <= k + 3'd1;
                end
                st_out: begin
                    out       <= y_sat;
                    out_valid <= 1'b1;
                    sat       <= y_ovf;
                    x2        <= x1;
                    x1        <= x0;
                    y2        <= y1;
                    y1        <= y_sat;   // feedback uses the clipped value
                    state     <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_df1.sv
// -----------------------------------------------------------------------------
// tb_biquad_df1 -- self-checking bench for biquad_df1.
//
// The reference model evaluates the difference equation directly on integer
// history variables, with floor division and clamping, and is stepped once
// per accepted sample. Directed cases cover reset, pass-through, unit delay,
// feedback, saturation, drop and mid-computation reset; a randomized phase
// follows with random coefficients, inputs, dropped strobes and idle gaps.
// -----------------------------------------------------------------------------
module tb_biquad_df1;

    localparam int n = 12;
    localparam int c = 12;
    localparam int f = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [n-1:0] in;
    logic                in_valid;
    logic signed [c-1:0] b0, b1, b2, a1, a2;
    logic signed [n-1:0] out;
    logic                out_valid;
    logic                busy;
    logic                sat;
    logic                drop;

    int checks = 0;
    int errors = 0;

    // Reference history.
    int m_x1, m_x2, m_y1, m_y2;

    biquad_df1 #(.n(n), .c(c), .f(f)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .a1        (a1),
        .a2        (a2),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .sat       (sat),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    endfunction

    // One sample through the difference equation with the given coefficients.
    function automatic int model_step(input int x, input int k0, input int k1,
                                      input int k2, input int k3, input int k4,
                                      output bit clip);
        longint s;
        longint q;
        int     y;
        s = longint'(k0) * x + longint'(k1) * m_x1 + longint'(k2) * m_x2
          - longint'(k3) * m_y1 - longint'(k4) * m_y2;
        if (s >= 0) q = s / (2 ** f);
        else        q = -((-s + (2 ** f) - 1) / (2 ** f));
        clip = 1'b0;
        if (q > (2 ** (n - 1)) - 1)      begin q = (2 ** (n - 1)) - 1; clip = 1'b1; end
        else if (q < -(2 ** (n - 1)))    begin q = -(2 ** (n - 1));    clip = 1'b1; end
        y    = int'(q);
        m_x2 = m_x1; m_x1 = x;
        m_y2 = m_y1; m_y1 = y;
        return y;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Present one sample, scramble the coefficient ports while it is being
    // processed, optionally strobe an extra in_valid sampled at edge T+inject
    // (1..6, 0 = none), then wait for the result and compare.
    task automatic send(input int x, input int inject);
        logic signed [c-1:0] s0, s1, s2, s3, s4;
        int  exp_y;
        bit  exp_sat;
        bit  seen;
        int  lat;
        s0 = b0; s1 = b1; s2 = b2; s3 = a1; s4 = a2;
        exp_y = model_step(x, int'(b0), int'(b1), int'(b2), int'(a1), int'(a2), exp_sat);

        in = n'(x); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_capture", busy, 1);
        b0 = c'($urandom); b1 = c'($urandom); b2 = c'($urandom);
        a1 = c'($urandom); a2 = c'($urandom);

        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (i == inject) begin in = n'($urandom); in_valid = 1'b1; end
            tick();
            in_valid = 1'b0;
            if (i == inject) check("drop_pulse", drop, 1);
            if (out_valid) begin seen = 1'b1; lat = i; end
        end
        if (!seen) begin
            check("out_valid_timeout", 0, 1);
        end else begin
            check("latency", lat, 6);
            check("out", int'(out), exp_y);
            check("sat", sat, int'(exp_sat));
        end
        b0 = s0; b1 = s1; b2 = s2; a1 = s3; a2 = s4;
    endtask

    task automatic set_coeffs(input int k0, input int k1, input int k2,
                              input int k3, input int k4);
        b0 = c'(k0); b1 = c'(k1); b2 = c'(k2); a1 = c'(k3); a2 = c'(k4);
    endtask

    initial begin
        int ov_count;
        rst = 1'b1; in = '0; in_valid = 1'b0;
        set_coeffs(0, 0, 0, 0, 0);
        model_reset();

        // Reset values.
        tick(); tick();
        check("rst_out", int'(out), 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        check("rst_drop", drop, 0);
        rst = 1'b0;

        // Pass-through.
        set_coeffs(1024, 0, 0, 0, 0);
        send(0, 0);
        send(100, 0);
        send(-37, 0);
        tick(); tick(); tick();
        check("out_hold", int'(out), -37);
        check("out_valid_idle", out_valid, 0);

        // Pure unit delay: 100,200,300 -> 0,100,200.
        do_reset();
        set_coeffs(0, 1024, 0, 0, 0);
        send(100, 0);
        send(200, 0);
        send(300, 0);

        // Feedback: impulse 400 -> 400,200,100,50,25,12.
        do_reset();
        set_coeffs(1024, 0, 0, -512, 0);
        send(400, 0);
        for (int i = 0; i < 5; i++) send(0, 0);

        // Saturation in both directions.
        do_reset();
        set_coeffs(2047, 0, 0, 0, 0);
        send(2047, 0);
        send(-2048, 0);

        // Strobe while busy is dropped and leaves history untouched.
        do_reset();
        set_coeffs(1024, 0, 0, 0, 0);
        send(300, 2);
        set_coeffs(0, 1024, 0, 0, 0);
        send(0, 0);
        set_coeffs(1024, 0, 0, 0, 0);
        send(-5, 6);   // strobe on the OUT->IDLE edge
        set_coeffs(0, 1024, 0, 0, 0);
        send(0, 0);

        // Reset in the middle of a computation.
        do_reset();
        set_coeffs(1024, 0, 0, 0, 0);
        send(123, 0);
        in = 12'sd55; in_valid = 1'b1;
        tick();                 // capture edge T
        in_valid = 1'b0;
        tick(); tick();         // T+1, T+2
        rst = 1'b1;
        tick();                 // T+3
        rst = 1'b0;
        model_reset();
        check("midrst_busy", busy, 0);
        check("midrst_out", int'(out), 0);
        ov_count = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) ov_count++;
            tick();
        end
        check("midrst_no_out_valid", ov_count, 0);
        set_coeffs(0, 1024, 0, 0, 0);
        send(77, 0);

        // Randomized phase.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int gap;
            if (i % 15 == 0)
                set_coeffs($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048,
                           $urandom_range(0, 4095) - 2048, $urandom_range(0, 2047) - 1024,
                           $urandom_range(0, 1023) - 512);
            send($urandom_range(0, 4095) - 2048, $urandom_range(0, 6));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("out_valid_gap", out_valid, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
